// File: rtl/pea_enable_scheduler_if.sv
// Command/population inputs and firing-control outputs between the PEA enable
// scheduler (master) and the FIFO/core side (slave).
interface pea_enable_scheduler_if #(
    parameter int word_size = 16
);
    logic [word_size-1:0] command_in;
    logic [word_size-1:0] command_pop;
    logic [word_size-1:0] data_pop;
    logic [word_size-1:0] result_free_space;
    logic [word_size-1:0] status_free_space;
    logic                 FC;
    logic                 invoke;
    logic [1:0]           next_instr;
    logic [7:0]           instr;
    logic [3:0]           arg_N;
    logic [4:0]           arg_b;
    logic                 busy;
    logic                 timeout;
    logic [15:0]          firing_count;

    modport master (
        input  command_in, command_pop, data_pop, result_free_space,
               status_free_space, FC,
        output invoke, next_instr, instr, arg_N, arg_b, busy, timeout,
               firing_count
    );

    modport slave (
        output command_in, command_pop, data_pop, result_free_space,
               status_free_space, FC,
        input  invoke, next_instr, instr, arg_N, arg_b, busy, timeout,
               firing_count
    );
endinterface

// File: rtl/pea_enable_scheduler.sv
// Firing scheduler for the PEA core: decodes the head command, waits for its
// enable condition, pulses invoke and tracks completion with a watchdog.
module pea_enable_scheduler #(
    parameter int word_size      = 16,
    parameter int buffer_size    = 1024,
    parameter int timeout_cycles = 4096
) (
    input logic                   clk,
    input logic                   rst,
    pea_enable_scheduler_if.master bus
);
    localparam int W1    = word_size + 1;
    localparam int WD_W  = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles - 1);

    localparam logic [1:0] CLS_STP = 2'b00;
    localparam logic [1:0] CLS_EVP = 2'b01;
    localparam logic [1:0] CLS_RST = 2'b10;
    localparam logic [1:0] CLS_INV = 2'b11;

    // Populations up to buffer_size must be representable in word_size bits.
    if (timeout_cycles < 1 || buffer_size >= (2 ** word_size)) begin : g_bad_params
        $error("pea_enable_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_CHECK, S_INVOKE, S_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [1:0]        next_instr_q;
    logic [7:0]        instr_q;
    logic [3:0]        arg_n_q;
    logic [4:0]        arg_b_q;
    logic              timeout_q;
    logic [15:0]       firing_count_q;
    logic              enable_ok;
    logic              fc_done;
    logic              wd_expired;
    logic [W1-1:0]     stp_need;
    logic [W1-1:0]     evp_need;

    function automatic logic [1:0] decode_class(input logic [7:0] op, input logic [4:0] a2);
        logic [1:0] cls;
        cls = CLS_INV;
        case (op)
            8'h01:   cls = CLS_STP;
            8'h02:   cls = (a2 != 5'd0) ? CLS_EVP : CLS_INV;
            8'h03:   cls = CLS_RST;
            default: cls = CLS_INV;
        endcase
        return cls;
    endfunction

    function automatic logic at_least(input logic [word_size-1:0] have, input logic [W1-1:0] need);
        return {1'b0, have} >= need;
    endfunction

    assign stp_need = W1'(arg_n_q) + W1'(1);
    assign evp_need = W1'(arg_b_q);

    always_comb begin
        enable_ok = 1'b0;
        case (next_instr_q)
            CLS_STP: enable_ok = at_least(bus.data_pop, stp_need)
                              && at_least(bus.status_free_space, W1'(1));
            CLS_EVP: enable_ok = at_least(bus.data_pop, evp_need)
                              && at_least(bus.result_free_space, evp_need)
                              && at_least(bus.status_free_space, W1'(1));
            default: enable_ok = at_least(bus.status_free_space, W1'(1));
        endcase
    end

    assign fc_done    = (state == S_WAIT) && bus.FC;
    assign wd_expired = (state == S_WAIT) && !bus.FC && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.command_pop != '0) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_CHECK;
            S_CHECK:  if (enable_ok) state_nxt = S_INVOKE;
            S_INVOKE: state_nxt = S_WAIT;
            S_WAIT:   if (fc_done || wd_expired) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.invoke = (state == S_INVOKE);
        bus.busy   = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_instr_q   <= CLS_STP;
            instr_q        <= '0;
            arg_n_q        <= '0;
            arg_b_q        <= '0;
            wd_cnt         <= '0;
            timeout_q      <= 1'b0;
            firing_count_q <= '0;
        end else begin
            if (state == S_DECODE) begin
                instr_q      <= bus.command_in[15:8];
                arg_n_q      <= bus.command_in[3:0];
                arg_b_q      <= bus.command_in[4:0];
                next_instr_q <= decode_class(bus.command_in[15:8], bus.command_in[4:0]);
            end
            // Watchdog restarts with every firing and only advances while waiting.
            if (state == S_INVOKE)    wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (fc_done)    firing_count_q <= firing_count_q + 16'd1;
            if (wd_expired) timeout_q      <= 1'b1;
        end
    end

    assign bus.next_instr   = next_instr_q;
    assign bus.instr        = instr_q;
    assign bus.arg_N        = arg_n_q;
    assign bus.arg_b        = arg_b_q;
    assign bus.timeout      = timeout_q;
    assign bus.firing_count = firing_count_q;
endmodule

// File: tb/tb_pea_enable_scheduler.sv
// Directed bench for pea_enable_scheduler: decode/enable vector table plus
// hand-written gating, watchdog, reset and back-to-back sequences.
module tb_pea_enable_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pea_enable_scheduler_if #(.word_size(16)) bus ();

    pea_enable_scheduler #(
        .word_size(16), .buffer_size(1024), .timeout_cycles(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] dpop;
        logic [15:0] rfree;
        logic [15:0] sfree;
        bit          en;
        logic [1:0]  ni;
        logic [7:0]  op;
        logic [3:0]  n;
        logic [4:0]  b;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.command_in        = '0;
        bus.command_pop       = '0;
        bus.data_pop          = '0;
        bus.result_free_space = '0;
        bus.status_free_space = '0;
        bus.FC                = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Leaves the DUT in INVOKE with the command withdrawn.
    task automatic run_to_invoke(input logic [15:0] cmd, input string tag);
        bus.command_in        = cmd;
        bus.command_pop       = 16'd1;
        bus.status_free_space = 16'd1;
        repeat (3) step();
        check({tag, " invoke"}, 32'(bus.invoke), 32'd1);
        bus.command_pop = 16'd0;
    endtask

    initial begin
        int inv_cnt;
        int first_at;
        int inv_steps[$];
        bit prev_inv;
        bit consec;
        bit fc_pending;
        int diff;

        vecs[0]  = '{16'h0103, 16'd3,  16'd0,  16'd1, 1'b0, 2'b00, 8'h01, 4'd3,  5'd3};
        vecs[1]  = '{16'h0103, 16'd4,  16'd0,  16'd1, 1'b1, 2'b00, 8'h01, 4'd3,  5'd3};
        vecs[2]  = '{16'h0103, 16'd4,  16'd0,  16'd0, 1'b0, 2'b00, 8'h01, 4'd3,  5'd3};
        vecs[3]  = '{16'h0205, 16'd10, 16'd4,  16'd1, 1'b0, 2'b01, 8'h02, 4'd5,  5'd5};
        vecs[4]  = '{16'h0205, 16'd10, 16'd5,  16'd1, 1'b1, 2'b01, 8'h02, 4'd5,  5'd5};
        vecs[5]  = '{16'h0205, 16'd4,  16'd5,  16'd1, 1'b0, 2'b01, 8'h02, 4'd5,  5'd5};
        vecs[6]  = '{16'h0200, 16'd0,  16'd0,  16'd1, 1'b1, 2'b11, 8'h02, 4'd0,  5'd0};
        vecs[7]  = '{16'h0200, 16'd0,  16'd0,  16'd0, 1'b0, 2'b11, 8'h02, 4'd0,  5'd0};
        vecs[8]  = '{16'h07AB, 16'd0,  16'd0,  16'd1, 1'b1, 2'b11, 8'h07, 4'hB,  5'h0B};
        vecs[9]  = '{16'h0300, 16'd0,  16'd0,  16'd1, 1'b1, 2'b10, 8'h03, 4'd0,  5'd0};
        vecs[10] = '{16'h0300, 16'd0,  16'd0,  16'd0, 1'b0, 2'b10, 8'h03, 4'd0,  5'd0};
        vecs[11] = '{16'h011F, 16'd16, 16'd0,  16'd1, 1'b1, 2'b00, 8'h01, 4'hF,  5'h1F};
        vecs[12] = '{16'h011F, 16'd15, 16'd0,  16'd1, 1'b0, 2'b00, 8'h01, 4'hF,  5'h1F};
        vecs[13] = '{16'h00FF, 16'd0,  16'd0,  16'd1, 1'b1, 2'b11, 8'h00, 4'hF,  5'h1F};
        vecs[14] = '{16'h021F, 16'd31, 16'd31, 16'd1, 1'b1, 2'b01, 8'h02, 4'hF,  5'h1F};

        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset invoke",     32'(bus.invoke),       32'd0);
        check("reset busy",       32'(bus.busy),         32'd0);
        check("reset timeout",    32'(bus.timeout),      32'd0);
        check("reset count",      32'(bus.firing_count), 32'd0);
        check("reset next_instr", 32'(bus.next_instr),   32'd0);
        check("reset instr",      32'(bus.instr),        32'd0);

        // Decode and enable table
        for (int i = 0; i < 15; i++) begin
            do_reset();
            bus.command_in        = vecs[i].cmd;
            bus.command_pop       = 16'd1;
            bus.data_pop          = vecs[i].dpop;
            bus.result_free_space = vecs[i].rfree;
            bus.status_free_space = vecs[i].sfree;
            inv_cnt  = 0;
            first_at = -1;
            for (int k = 1; k <= 8; k++) begin
                step();
                if (bus.invoke) begin
                    inv_cnt++;
                    if (first_at < 0) first_at = k;
                end
            end
            check($sformatf("v%0d invoke count", i), 32'(inv_cnt), vecs[i].en ? 32'd1 : 32'd0);
            check($sformatf("v%0d invoke cycle", i), 32'(first_at), vecs[i].en ? 32'd3 : 32'hFFFF_FFFF);
            check($sformatf("v%0d next_instr", i), 32'(bus.next_instr), 32'(vecs[i].ni));
            check($sformatf("v%0d instr", i),      32'(bus.instr),      32'(vecs[i].op));
            check($sformatf("v%0d arg_N", i),      32'(bus.arg_N),      32'(vecs[i].n));
            check($sformatf("v%0d arg_b", i),      32'(bus.arg_b),      32'(vecs[i].b));
            check($sformatf("v%0d busy", i),       32'(bus.busy),       32'd1);
            if (vecs[i].en) begin
                bus.FC          = 1'b1;
                bus.command_pop = 16'd0;
                step();
                bus.FC = 1'b0;
                check($sformatf("v%0d count", i),     32'(bus.firing_count), 32'd1);
                check($sformatf("v%0d idle busy", i), 32'(bus.busy),         32'd0);
            end
        end

        // STP gating released by a data population change
        do_reset();
        bus.command_in        = 16'h0103;
        bus.command_pop       = 16'd1;
        bus.data_pop          = 16'd3;
        bus.status_free_space = 16'd1;
        inv_cnt = 0;
        repeat (6) begin
            step();
            if (bus.invoke) inv_cnt++;
        end
        check("stp gated invokes", 32'(inv_cnt), 32'd0);
        bus.data_pop = 16'd4;
        step();
        check("stp release invoke", 32'(bus.invoke),     32'd1);
        check("stp next_instr",     32'(bus.next_instr), 32'd0);
        check("stp arg_N",          32'(bus.arg_N),      32'd3);
        step();
        check("stp invoke single",  32'(bus.invoke),     32'd0);
        bus.command_pop = 16'd0;
        step();
        bus.FC = 1'b1;
        step();
        bus.FC = 1'b0;
        check("stp count", 32'(bus.firing_count), 32'd1);
        check("stp idle",  32'(bus.busy),         32'd0);

        // EVP gating released by result free space
        do_reset();
        bus.command_in        = 16'h0205;
        bus.command_pop       = 16'd1;
        bus.data_pop          = 16'd10;
        bus.result_free_space = 16'd4;
        bus.status_free_space = 16'd1;
        inv_cnt = 0;
        repeat (5) begin
            step();
            if (bus.invoke) inv_cnt++;
        end
        check("evp gated invokes", 32'(inv_cnt), 32'd0);
        bus.result_free_space = 16'd5;
        step();
        check("evp release invoke", 32'(bus.invoke),     32'd1);
        check("evp next_instr",     32'(bus.next_instr), 32'd1);
        check("evp arg_b",          32'(bus.arg_b),      32'd5);

        // Watchdog expiry: 8 cycles in WAIT without FC
        do_reset();
        run_to_invoke(16'h0300, "wd");
        step();
        repeat (7) step();
        check("wd before expiry timeout", 32'(bus.timeout), 32'd0);
        check("wd before expiry busy",    32'(bus.busy),    32'd1);
        step();
        check("wd timeout",      32'(bus.timeout),      32'd1);
        check("wd idle",         32'(bus.busy),         32'd0);
        check("wd count kept",   32'(bus.firing_count), 32'd0);

        // Timeout flag survives a later successful firing
        run_to_invoke(16'h0300, "sticky");
        step();
        bus.FC = 1'b1;
        step();
        bus.FC = 1'b0;
        check("sticky count",   32'(bus.firing_count), 32'd1);
        check("sticky timeout", 32'(bus.timeout),      32'd1);

        // Reset asserted while waiting for FC
        run_to_invoke(16'h0300, "midwait");
        step();
        check("midwait busy before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midwait invoke",     32'(bus.invoke),       32'd0);
        check("midwait busy",       32'(bus.busy),         32'd0);
        check("midwait count",      32'(bus.firing_count), 32'd0);
        check("midwait timeout",    32'(bus.timeout),      32'd0);
        check("midwait next_instr", 32'(bus.next_instr),   32'd0);
        check("midwait instr",      32'(bus.instr),        32'd0);
        step();
        check("midwait stays idle", 32'(bus.busy), 32'd0);

        // FC on the last watchdog cycle beats the timeout
        do_reset();
        run_to_invoke(16'h0300, "race");
        step();
        repeat (7) step();
        bus.FC = 1'b1;
        step();
        bus.FC = 1'b0;
        check("race timeout", 32'(bus.timeout),      32'd0);
        check("race count",   32'(bus.firing_count), 32'd1);
        check("race idle",    32'(bus.busy),         32'd0);

        // Two queued RST commands back to back
        do_reset();
        bus.command_in        = 16'h0300;
        bus.command_pop       = 16'd2;
        bus.status_free_space = 16'd1;
        prev_inv   = 1'b0;
        consec     = 1'b0;
        fc_pending = 1'b0;
        for (int s = 1; s <= 20; s++) begin
            step();
            bus.FC = 1'b0;
            if (bus.invoke) begin
                if (prev_inv) consec = 1'b1;
                inv_steps.push_back(s);
                fc_pending = 1'b1;
            end else if (fc_pending) begin
                bus.FC          = 1'b1;
                bus.command_pop = bus.command_pop - 16'd1;
                fc_pending      = 1'b0;
            end
            prev_inv = bus.invoke;
        end
        diff = (inv_steps.size() >= 2) ? inv_steps[1] - inv_steps[0] : -1;
        check("b2b invoke pulses",  32'(inv_steps.size()), 32'd2);
        check("b2b spacing",        32'(diff),             32'd5);
        check("b2b no consecutive", 32'(consec),           32'd0);
        check("b2b count",          32'(bus.firing_count), 32'd2);
        check("b2b idle",           32'(bus.busy),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pea_enable_scheduler.md
Name: pea_enable_scheduler

Overview:
- Upstream firing scheduler for the PEA core; drives its `invoke` and `next_instr` inputs.
- Watches the Control Input FIFO, latches and decodes the head command token, then checks the enable condition for that instruction.
- Enable condition covers input data population and output free space.
- Issues a one-cycle `invoke`, then waits for the core's firing-complete (FC) signal before scheduling the next command. A watchdog flags firings that never complete.

Parameters:
- word_size, 16, width of command/data tokens and of FIFO population/free-space counts
- buffer_size, 1024, words per FIFO; populations and free-space values never exceed this
- timeout_cycles, 4096, max cycles in WAIT before watchdog fires; must be ≥ 1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- command_in  in  word_size  head token of Control Input FIFO (first-word-fall-through, valid when command_pop ≠ 0); [15:8] opcode, [7:5] arg1, [4:0] arg2
- command_pop  in  word_size  Control Input FIFO population
- data_pop  in  word_size  Data Input FIFO population
- result_free_space  in  word_size  free words in Result Output FIFO
- status_free_space  in  word_size  free words in Status Output FIFO
- FC  in  1  firing complete from PEA core
- invoke  out  1  one-cycle firing request to core
- next_instr  out  2  decoded class: 00 STP, 01 EVP, 10 RST, 11 INVALID
- instr  out  8  latched opcode
- arg_N  out  4  latched arg2[3:0] (polynomial degree)
- arg_b  out  5  latched arg2 (evaluation count)
- busy  out  1  high in any state other than IDLE
- timeout  out  1  sticky watchdog flag
- firing_count  out  16  number of completed firings

Behaviour:
- Reset (rst=1 at clk edge) has priority over everything and applies in any state, including mid-WAIT:
  - state goes to IDLE
  - invoke, busy, timeout = 0
  - next_instr = 2'b00; instr, arg_N, arg_b = 0
  - firing_count = 0; watchdog counter = 0
- Opcode decode:
  - 8'h01 → STP
  - 8'h02 → EVP if arg2 ≠ 0, otherwise INVALID
  - 8'h03 → RST
  - any other opcode → INVALID
- Enable conditions; all compares are unsigned, widened to word_size+1 bits so N+1 cannot overflow:
  - STP: data_pop ≥ arg_N+1 AND status_free_space ≥ 1
  - EVP: data_pop ≥ arg_b AND result_free_space ≥ arg_b AND status_free_space ≥ 1
  - RST: status_free_space ≥ 1
  - INVALID: status_free_space ≥ 1 (the core emits an error status)
- States:
  - IDLE: busy=0. If command_pop ≠ 0 → DECODE, else stay.
  - DECODE (1 cycle): latch command_in into instr/arg_N/arg_b, register next_instr → CHECK. This block never drives a command read; the core pops the command during its firing.
  - CHECK: evaluate the enable condition on the latched values each cycle. True → INVOKE; false → stay indefinitely, no timeout in this state.
  - INVOKE (exactly 1 cycle): invoke=1, watchdog cleared → WAIT. FC is ignored in this state.
  - WAIT: watchdog increments each cycle.
    - FC=1 → IDLE, firing_count increments (wraps 16'hFFFF → 0).
    - Else if watchdog = timeout_cycles−1 → timeout=1 (sticky until rst), go to IDLE; firing_count unchanged.
    - FC and timeout in the same cycle: FC wins, timeout is not set.
- Timing:
  - invoke is a registered state decode; it is never high on consecutive cycles.
  - Minimum command-arrival-to-invoke latency is 3 cycles: IDLE→DECODE→CHECK→INVOKE, with invoke high in the 3rd cycle after command_pop becomes nonzero.
- next_instr, instr, arg_N and arg_b hold stable from the end of DECODE until the next DECODE.
- Population changes during WAIT have no effect; conditions are re-evaluated only in CHECK.

Test Plan:
- Reset mid-WAIT (rst=1 one cycle): next cycle state IDLE; invoke=0, busy=0, firing_count=0, timeout=0.
- STP gating: command 16'h0103 (STP, N=3), data_pop=3 → stays in CHECK with no invoke. Raise data_pop to 4 → invoke pulses once 1 cycle later, next_instr=00, arg_N=3. FC=1 two cycles later → IDLE, firing_count=1.
- EVP output-space gating: command 16'h0205 (b=5), data_pop=10, result_free_space=4 → no invoke. result_free_space=5 → invoke, next_instr=01, arg_b=5.
- Invalid handling:
  - command 16'h0200 (EVP, b=0) → next_instr=11; invoke issued once status_free_space ≥ 1.
  - command 16'h07xx → next_instr=11.
  - status_free_space=0 → no invoke.
- Watchdog with timeout_cycles=8: after invoke, FC held 0 → timeout=1 exactly 8 cycles after entering WAIT, back to IDLE, firing_count unchanged. FC coincident with the final cycle → timeout stays 0, count increments.
- Back-to-back: command_pop=2, two RST commands 16'h0300 with FC returned 1 cycle after each invoke → two invoke pulses 5 cycles apart, firing_count=2, invoke never high two cycles in a row.
